digit_serial_adder: RTL and testbench

//   Parametrised multi-cycle add/subtract unit. Adds two WIDTH-bit operands DIGIT bits per

---
 rtl/digit_serial_adder_pkg.sv | 27 ++
 rtl/digit_serial_adder_if.sv | 27 ++
 rtl/digit_serial_adder_digit_adder.sv | 24 ++
 rtl/digit_serial_adder.sv | 112 +++++++++++
 tb/tb_digit_serial_adder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// constant-width helpers used to size the digit counter.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Counter is never narrower than one bit, even when a single digit covers the word.
    function automatic int cnt_width(input int ndig);
        return (clog2(ndig) < 1) ? 1 : clog2(ndig);
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for digit_serial_adder: valid/ready on the
// operand side and on the result side.
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder from full-adder cells; also exposes the
// carry into the top bit so the caller can derive signed overflow.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_c,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_carry,
    output logic             o_carry_msb
);
    logic [DIGIT:0] w_c;

    assign w_c[0] = i_c;

    for (genvar g = 0; g < DIGIT; g++) begin : g_fa
        assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1]  = (i_a[g] & i_b[g]) | (i_b[g] & w_c[g]) | (w_c[g] & i_a[g]);
    end

    assign o_carry     = w_c[DIGIT];
    assign o_carry_msb = w_c[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract unit: processes DIGIT bits per clock, LSB digit first,
// with valid/ready handshakes on operands and result.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    digit_serial_adder_if.slave  bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("digit_serial_adder: WIDTH must be a multiple of DIGIT and 1 <= DIGIT <= WIDTH");
    end

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_sub;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [31:0]      w_base;
    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0] w_dig_sum;
    logic             w_dig_carry;
    logic             w_carry_msb;

    assign w_base  = 32'(r_cnt) * 32'(DIGIT);
    assign w_a_dig = r_a[w_base +: DIGIT];
    assign w_b_dig = r_b[w_base +: DIGIT];

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .i_a         (w_a_dig),
        .i_b         (w_b_dig),
        .i_c         (r_carry),
        .o_sum       (w_dig_sum),
        .o_carry     (w_dig_carry),
        .o_carry_msb (w_carry_msb)
    );

    // Subtraction is a + ~b + 1, so b is inverted and the borrow folded into the carry at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_sub       <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b ^ {WIDTH{bus.sub}};
                        r_carry    <= bus.carry_in ^ bus.sub;
                        r_sub      <= bus.sub;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[w_base +: DIGIT] <= w_dig_sum;
                    r_carry                <= w_dig_carry;
                    if (r_cnt == CW'(NDIG - 1)) begin
                        r_carry_out <= w_dig_carry ^ r_sub;
                        r_overflow  <= w_carry_msb ^ w_dig_carry;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed-vector bench for digit_serial_adder at 8/2, plus random sweeps at
// 16/16 and 16/1 against an arithmetic reference.
module tb_digit_serial_adder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    digit_serial_adder_if #(.WIDTH(8))  if8 ();
    digit_serial_adder_if #(.WIDTH(16)) if16w ();
    digit_serial_adder_if #(.WIDTH(16)) if16s ();

    digit_serial_adder #(.WIDTH(8),  .DIGIT(2))  u_dut8   (.clk(clk), .rst(rst), .bus(if8));
    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut16w (.clk(clk), .rst(rst), .bus(if16w));
    digit_serial_adder #(.WIDTH(16), .DIGIT(1))  u_dut16s (.clk(clk), .rst(rst), .bus(if16s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sb;
        logic [7:0] exp_sum;
        logic       exp_co;
        logic       exp_ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sb, input logic v);
        case (sel)
            0: begin if8.in_valid = v; if8.a = a[7:0]; if8.b = b[7:0]; if8.carry_in = cin; if8.sub = sb; end
            1: begin if16w.in_valid = v; if16w.a = a; if16w.b = b; if16w.carry_in = cin; if16w.sub = sb; end
            default: begin if16s.in_valid = v; if16s.a = a; if16s.b = b; if16s.carry_in = cin; if16s.sub = sb; end
        endcase
    endtask

    task automatic set_ready(input int sel, input logic r);
        case (sel)
            0: if8.out_ready = r;
            1: if16w.out_ready = r;
            default: if16s.out_ready = r;
        endcase
    endtask

    task automatic sample(input int sel, output logic vld, output logic rdy,
                          output logic [15:0] s, output logic co, output logic ov);
        case (sel)
            0: begin vld = if8.out_valid; rdy = if8.in_ready; s = {8'h00, if8.sum}; co = if8.carry_out; ov = if8.overflow; end
            1: begin vld = if16w.out_valid; rdy = if16w.in_ready; s = if16w.sum; co = if16w.carry_out; ov = if16w.overflow; end
            default: begin vld = if16s.out_valid; rdy = if16s.in_ready; s = if16s.sum; co = if16s.carry_out; ov = if16s.overflow; end
        endcase
    endtask

    // Accept one operand set, scramble the inputs afterwards, and wait (bounded) for out_valid.
    task automatic start_wait(input int sel, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic sb,
                              output logic [15:0] s, output logic co, output logic ov, output int lat);
        logic vld, rdy;
        drive(sel, a, b, cin, sb, 1'b1);
        @(posedge clk); #1;
        drive(sel, ~a, ~b, ~cin, ~sb, 1'b0);
        lat = 0;
        sample(sel, vld, rdy, s, co, ov);
        while (!vld && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            sample(sel, vld, rdy, s, co, ov);
        end
    endtask

    task automatic release_result(input int sel);
        set_ready(sel, 1'b1);
        @(posedge clk); #1;
        set_ready(sel, 1'b0);
    endtask

    task automatic golden16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sb,
                            output logic [15:0] s, output logic co, output logic ov);
        logic [16:0] full;
        if (!sb) begin
            full = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
            ov   = (a[15] == b[15]) && (full[15] != a[15]);
        end else begin
            full = {1'b0, a} - {1'b0, b} - {16'h0000, cin};
            ov   = (a[15] != b[15]) && (full[15] != a[15]);
        end
        s  = full[15:0];
        co = full[16];
    endtask

    initial begin
        vec_t        vecs[9];
        logic [15:0] s, s0, es;
        logic        co, ov, co0, ov0, eco, eov, vld, rdy;
        int          lat;
        bit          saw_valid;

        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{8'd200, 8'd100, 1'b0, 1'b0, 8'd44,  1'b1, 1'b0};
        vecs[1] = '{8'd127, 8'd1,   1'b0, 1'b0, 8'd128, 1'b0, 1'b1};
        vecs[2] = '{8'd255, 8'd0,   1'b1, 1'b0, 8'd0,   1'b1, 1'b0};
        vecs[3] = '{8'd5,   8'd7,   1'b0, 1'b1, 8'd254, 1'b1, 1'b0};
        vecs[4] = '{8'd128, 8'd1,   1'b0, 1'b1, 8'd127, 1'b0, 1'b1};
        vecs[5] = '{8'd3,   8'd4,   1'b0, 1'b0, 8'd7,   1'b0, 1'b0};
        vecs[6] = '{8'd0,   8'd0,   1'b1, 1'b1, 8'd255, 1'b1, 1'b0};
        vecs[7] = '{8'd100, 8'd100, 1'b0, 1'b0, 8'd200, 1'b0, 1'b1};
        vecs[8] = '{8'd10,  8'd3,   1'b0, 1'b1, 8'd7,   1'b0, 1'b0};

        for (int i = 0; i < 3; i++) begin
            drive(i, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
            set_ready(i, 1'b0);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        sample(0, vld, rdy, s, co, ov);
        chk("reset_in_ready", 32'(rdy), 32'd1);
        chk("reset_out_valid", 32'(vld), 32'd0);
        chk("reset_sum", 32'(s), 32'd0);
        chk("reset_carry_out", 32'(co), 32'd0);
        chk("reset_overflow", 32'(ov), 32'd0);

        for (int i = 0; i < 9; i++) begin
            start_wait(0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].cin, vecs[i].sb, s, co, ov, lat);
            chk($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].exp_sum));
            chk($sformatf("vec%0d_carry_out", i), 32'(co), 32'(vecs[i].exp_co));
            chk($sformatf("vec%0d_overflow", i), 32'(ov), 32'(vecs[i].exp_ov));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            release_result(0);
        end

        // Result held while out_ready stays low; new operands offered meanwhile are ignored.
        start_wait(0, 16'd50, 16'd60, 1'b0, 1'b0, s0, co0, ov0, lat);
        chk("hold_first_sum", 32'(s0), 32'd110);
        for (int c = 0; c < 10; c++) begin
            drive(0, 16'(c + 1), 16'd77, 1'b1, 1'b1, 1'b1);
            @(posedge clk); #1;
            sample(0, vld, rdy, s, co, ov);
            chk("hold_out_valid", 32'(vld), 32'd1);
            chk("hold_in_ready", 32'(rdy), 32'd0);
            chk("hold_sum", 32'(s), 32'd110);
            chk("hold_flags", {30'd0, co, ov}, {30'd0, co0, ov0});
        end
        drive(0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        release_result(0);
        sample(0, vld, rdy, s, co, ov);
        chk("release_out_valid", 32'(vld), 32'd0);
        chk("release_in_ready", 32'(rdy), 32'd1);
        start_wait(0, 16'd1, 16'd2, 1'b0, 1'b0, s, co, ov, lat);
        chk("after_hold_sum", 32'(s), 32'd3);
        release_result(0);

        // Reset during the second RUN cycle discards the operation.
        drive(0, 16'd9, 16'd9, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sample(0, vld, rdy, s, co, ov);
        chk("abort_in_ready", 32'(rdy), 32'd1);
        chk("abort_out_valid", 32'(vld), 32'd0);
        chk("abort_sum", 32'(s), 32'd0);
        saw_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            sample(0, vld, rdy, s, co, ov);
            if (vld) saw_valid = 1'b1;
        end
        chk("abort_no_valid", 32'(saw_valid), 32'd0);
        start_wait(0, 16'd3, 16'd4, 1'b0, 1'b0, s, co, ov, lat);
        chk("after_abort_sum", 32'(s), 32'd7);
        chk("after_abort_latency", 32'(lat), 32'd4);
        release_result(0);

        for (int sel = 1; sel < 3; sel++) begin
            for (int n = 0; n < 1000; n++) begin
                logic [15:0] ra, rb;
                logic        rc, rs;
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                rs = 1'($urandom);
                golden16(ra, rb, rc, rs, es, eco, eov);
                start_wait(sel, ra, rb, rc, rs, s, co, ov, lat);
                chk($sformatf("rand%0d_sum", sel), 32'(s), 32'(es));
                chk($sformatf("rand%0d_carry_out", sel), 32'(co), 32'(eco));
                chk($sformatf("rand%0d_overflow", sel), 32'(ov), 32'(eov));
                chk($sformatf("rand%0d_latency", sel), 32'(lat), (sel == 1) ? 32'd1 : 32'd16);
                release_result(sel);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
